// File: rtl/sequencer_pkg.sv
// Shared constants, opcode encodings and types for the instruction sequencer.
// Field layout of a 13-bit word: [12:9] opcode, [8:6] Rs, [5:3] Rt, [2:0] Rd.
package sequencer_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int IW    = 13;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OPC_MSB = 12;
  localparam int OPC_LSB = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;
  localparam int RD_MSB  = 2;
  localparam int RD_LSB  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic [3:0] opcode;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
  } instr_t;

  function automatic instr_t decode(input logic [IW-1:0] word);
    instr_t f;
    f.opcode = word[OPC_MSB:OPC_LSB];
    f.rs     = word[RS_MSB:RS_LSB];
    f.rt     = word[RT_MSB:RT_LSB];
    f.rd     = word[RD_MSB:RD_LSB];
    return f;
  endfunction

endpackage

// File: rtl/instr_rom.sv
// Program memory: synchronous write from the load port, asynchronous read at the PC.
// Contents are deliberately not reset so a program survives a sequencer reset.
module instr_rom #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 13
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [IW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [IW-1:0] rdata
);

  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// Issues one instruction per unstalled clock from program memory into the Processor
// until a HALT word or the last memory word is reached.
//
// state | meaning
// IDLE  | after reset; program may be loaded; waiting for start
// RUN   | fetching/issuing at pc; load and start ignored
// DONE  | HALT or end of memory reached; done held; load or restart allowed
module instr_sequencer
  import sequencer_pkg::*;
#(
  parameter int DEPTH = sequencer_pkg::DEPTH,
  parameter int AW    = sequencer_pkg::AW,
  parameter int IW    = sequencer_pkg::IW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [IW-1:0] load_data,
  input  logic          start,
  input  logic          stall,
  output logic [3:0]    Opcode,
  output logic [2:0]    Rs,
  output logic [2:0]    Rt,
  output logic [2:0]    Rd,
  output logic          issue_valid,
  output logic [AW-1:0] pc,
  output logic          busy,
  output logic          done
);

  seq_state_t    state_q, state_n;
  logic [AW-1:0] pc_q, pc_n;
  instr_t        fields_q, fields_n;
  logic          valid_q, valid_n;
  logic          done_q, done_n;
  logic [IW-1:0] word;
  instr_t        word_f;
  logic          mem_we;

  // Loads are blocked while running so the program under execution cannot change.
  assign mem_we = load_en && (state_q != RUN);

  instr_rom #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_rom (
    .clk   (clk),
    .we    (mem_we),
    .waddr (load_addr),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (word)
  );

  assign word_f = decode(word);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      fields_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      fields_q <= fields_n;
      valid_q  <= valid_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    fields_n = fields_q;
    valid_n  = 1'b0;
    done_n   = done_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_n = RUN;
          pc_n    = '0;
          done_n  = 1'b0;
        end
      end
      RUN: begin
        // Stall is checked first so a stalled HALT is only taken once released.
        if (!stall) begin
          if (word_f.opcode == OP_HALT) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            fields_n = word_f;
            valid_n  = 1'b1;
            pc_n     = pc_q + 1'b1;
            if (pc_q == AW'(DEPTH - 1)) begin
              state_n = DONE;
              done_n  = 1'b1;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign Opcode      = fields_q.opcode;
  assign Rs          = fields_q.rs;
  assign Rt          = fields_q.rt;
  assign Rd          = fields_q.rd;
  assign issue_valid = valid_q;
  assign pc          = pc_q;
  assign busy        = (state_q == RUN);
  assign done        = done_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer; outputs sampled on the falling edge.
module tb_instr_sequencer;
  import sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_en = 1'b0;
  logic [3:0]  load_addr = '0;
  logic [12:0] load_data = '0;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic [3:0]  Opcode;
  logic [2:0]  Rs, Rt, Rd;
  logic        issue_valid;
  logic [3:0]  pc;
  logic        busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  instr_sequencer dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
    .start(start), .stall(stall), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
    .issue_valid(issue_valid), .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Observation vector: {issue_valid, busy, done, pc[3:0], Opcode[3:0], Rs, Rt, Rd}
  function automatic logic [19:0] snap();
    return {issue_valid, busy, done, pc, Opcode, Rs, Rt, Rd};
  endfunction

  function automatic logic [19:0] ev(input logic iv, input logic bz, input logic dn,
                                     input logic [3:0] p, input logic [3:0] op,
                                     input logic [2:0] s, input logic [2:0] t, input logic [2:0] d);
    return {iv, bz, dn, p, op, s, t, d};
  endfunction

  function automatic logic [12:0] mk(input logic [3:0] op, input logic [2:0] s,
                                     input logic [2:0] t, input logic [2:0] d);
    return {op, s, t, d};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_word(input logic [3:0] a, input logic [12:0] w);
    load_en = 1'b1; load_addr = a; load_data = w;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++; if (snap() !== 20'h0) begin n_bad++; $display("FAIL reset_hold got %h want %h", snap(), 20'h0); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (snap() !== 20'h0) begin n_bad++; $display("FAIL reset_idle got %h want %h", snap(), 20'h0); end
  endtask

  task automatic test_basic();
    logic [19:0] e;
    load_word(4'd0, mk(OP_ADD, 3, 2, 1));
    load_word(4'd1, mk(OP_SUB, 3, 2, 1));
    load_word(4'd2, mk(OP_HALT, 0, 0, 0));
    pulse_start();
    e = ev(0, 1, 0, 4'd0, 4'd0, 0, 0, 0);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL basic_run got %h want %h", snap(), e); end
    tick();
    e = ev(1, 1, 0, 4'd1, OP_ADD, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL basic_add got %h want %h", snap(), e); end
    tick();
    e = ev(1, 1, 0, 4'd2, OP_SUB, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL basic_sub got %h want %h", snap(), e); end
    tick();
    e = ev(0, 0, 1, 4'd2, OP_SUB, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL basic_halt got %h want %h", snap(), e); end
  endtask

  task automatic test_stall();
    logic [19:0] e;
    pulse_start();
    e = ev(0, 1, 0, 4'd0, OP_SUB, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL stall_run got %h want %h", snap(), e); end
    tick();
    e = ev(1, 1, 0, 4'd1, OP_ADD, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL stall_first got %h want %h", snap(), e); end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    e = ev(0, 1, 0, 4'd1, OP_ADD, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL stall_hold got %h want %h", snap(), e); end
    tick();
    e = ev(1, 1, 0, 4'd2, OP_SUB, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL stall_second got %h want %h", snap(), e); end
    stall = 1'b1;
    tick();
    stall = 1'b0;
    e = ev(0, 1, 0, 4'd2, OP_SUB, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL stall_on_halt got %h want %h", snap(), e); end
    tick();
    e = ev(0, 0, 1, 4'd2, OP_SUB, 3, 2, 1);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL stall_then_halt got %h want %h", snap(), e); end
  endtask

  task automatic test_full_wrap();
    logic [19:0] e;
    int issues;
    issues = 0;
    for (int a = 0; a < 16; a++) load_word(4'(a), mk(OP_XOR, 1, 2, 0));
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      tick();
      if (issue_valid === 1'b1) issues++;
      e = ev(1, (i != 15), (i == 15), 4'(i + 1), OP_XOR, 1, 2, 0);
      n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL wrap_issue%0d got %h want %h", i, snap(), e); end
    end
    tick();
    e = ev(0, 0, 1, 4'd0, OP_XOR, 1, 2, 0);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL wrap_end got %h want %h", snap(), e); end
    n_cmp++; if (issues !== 16) begin n_bad++; $display("FAIL wrap_count got %0d want 16", issues); end
  endtask

  task automatic test_reset_mid_run();
    logic [19:0] e;
    load_word(4'd0, mk(OP_OR, 5, 6, 7));
    load_word(4'd1, mk(OP_HALT, 0, 0, 0));
    pulse_start();
    tick();
    e = ev(1, 1, 0, 4'd1, OP_OR, 5, 6, 7);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL rstmid_issue got %h want %h", snap(), e); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (snap() !== 20'h0) begin n_bad++; $display("FAIL rstmid_async got %h want %h", snap(), 20'h0); end
    tick();
    rst = 1'b0;
    tick();
    n_cmp++; if (snap() !== 20'h0) begin n_bad++; $display("FAIL rstmid_idle got %h want %h", snap(), 20'h0); end
    pulse_start();
    tick();
    e = ev(1, 1, 0, 4'd1, OP_OR, 5, 6, 7);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL rstmid_rerun got %h want %h", snap(), e); end
    tick();
    e = ev(0, 0, 1, 4'd1, OP_OR, 5, 6, 7);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL rstmid_done got %h want %h", snap(), e); end
  endtask

  task automatic test_load_in_run();
    logic [19:0] e;
    load_word(4'd0, mk(OP_AND, 1, 2, 3));
    load_word(4'd1, mk(OP_SHL, 4, 5, 6));
    load_word(4'd2, mk(OP_HALT, 0, 0, 0));
    pulse_start();
    load_en = 1'b1; load_addr = 4'd0; load_data = mk(OP_NOT, 1, 0, 0);
    start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    e = ev(1, 1, 0, 4'd1, OP_AND, 1, 2, 3);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL run_load_first got %h want %h", snap(), e); end
    tick();
    e = ev(1, 1, 0, 4'd2, OP_SHL, 4, 5, 6);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL run_start_ignored got %h want %h", snap(), e); end
    tick();
    e = ev(0, 0, 1, 4'd2, OP_SHL, 4, 5, 6);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL run_load_done got %h want %h", snap(), e); end
    pulse_start();
    tick();
    e = ev(1, 1, 0, 4'd1, OP_AND, 1, 2, 3);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL run_load_kept got %h want %h", snap(), e); end
    tick();
    tick();
    load_word(4'd0, mk(OP_NOT, 1, 0, 0));
    pulse_start();
    tick();
    e = ev(1, 1, 0, 4'd1, OP_NOT, 1, 0, 0);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL reload_not got %h want %h", snap(), e); end
    tick();
    tick();
    e = ev(0, 0, 1, 4'd2, OP_SHL, 4, 5, 6);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL reload_done got %h want %h", snap(), e); end
  endtask

  task automatic test_load_with_start();
    logic [19:0] e;
    load_en = 1'b1; load_addr = 4'd0; load_data = mk(OP_HALT, 0, 0, 0);
    start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    e = ev(0, 1, 0, 4'd0, OP_SHL, 4, 5, 6);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL ldstart_run got %h want %h", snap(), e); end
    tick();
    e = ev(0, 0, 1, 4'd0, OP_SHL, 4, 5, 6);
    n_cmp++; if (snap() !== e) begin n_bad++; $display("FAIL ldstart_halt got %h want %h", snap(), e); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_full_wrap();
    test_reset_mid_run();
    test_load_in_run();
    test_load_with_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
